program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Upstream stage of the 16-bit main memory. Accepts a program image as a valid/ready word stream.
//  Writes the image into memory through the memory's Address/DataIn/MemWrite port.
//  Holds the CPU halted while loading and releases it once the image is loaded and checked.
//  Image format: length word N, then N data words, then a checksum word (sum of data words mod 2^16).
// PARAMETERS
//  ADDR_W     16   memory address width
//  DATA_W     16   memory/stream word width
//  BASE_ADDR  0    memory address of the first data word
//  MAX_WORDS  257  largest accepted N (memory depth). BASE_ADDR+MAX_WORDS <= 2^ADDR_W; elaboration error otherwise.
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       synchronous, active-low reset
//  start        in   1       one-cycle pulse; begins a load from IDLE, DONE or ERR
//  in_data      in   DATA_W  stream word
//  in_valid     in   1       in_data valid
//  in_ready     out  1       loader can accept; a word transfers when in_valid & in_ready at a rising edge
//  Address      out  ADDR_W  memory address (registered)
//  DataIn       out  DATA_W  memory write data (registered)
//  MemWrite     out  1       memory write strobe (registered, one cycle per word)
//  MemVal       in   DATA_W  memory read data; valid one cycle after Address is presented with MemWrite=0
//  cpu_hold     out  1       1 = CPU held halted
//  done         out  1       image loaded and checked
//  error        out  1       load failed
//  err_code     out  2       1 = bad length, 2 = checksum mismatch, 3 = readback mismatch
//  words_loaded out  ADDR_W  data words written in the current load
// BEHAVIOUR
//  Reset (reset==0 at an edge): state IDLE. All outputs 0, including Address, DataIn and err_code.
//  States and transitions:
//   IDLE: in_ready=0, cpu_hold=0. start -> HDR.
//   HDR: in_ready=1, cpu_hold=1. On transfer, capture N.
//        N==0 or N>MAX_WORDS -> ERR, err_code 1, no writes. Otherwise -> DATA with count=0, sum=0.
//   DATA: in_ready=1. Each transfer registers Address=BASE_ADDR+count, DataIn=in_data and MemWrite=1.
//        sum+=in_data (mod 2^16). count++, and words_loaded follows count.
//        Back-to-back transfers allowed (1 word/cycle). MemWrite=0 in any cycle without a transfer.
//        After the Nth transfer -> CSUM.
//   CSUM: in_ready=1. On transfer: word==sum -> DONE (VERIFY when enabled); else ERR, err_code 2.
//   DONE: done=1, cpu_hold=0, in_ready=0. start -> HDR and clears done.
//   ERR: error=1, cpu_hold=1 (CPU stays halted), in_ready=0. start -> HDR and clears error/err_code.
//  Latency: a word accepted at edge k is written to memory at edge k+1.
//  done/error assert at the edge after the checksum transfer.
//  start while in HDR/DATA/CSUM/VERIFY: ignored.
//  in_valid with in_ready=0: no transfer, and the word is not consumed.
//  start and a transfer in the same cycle: start wins only in IDLE/DONE/ERR, where in_ready=0.
//  Reset mid-load: IDLE and MemWrite=0 at that edge; words already written stay in memory; words_loaded=0.
//  Address never wraps: N is capped and BASE_ADDR+MAX_WORDS is bounded at elaboration.
// CONFIGURATION
//  LOADER_VERIFY_EN defined:
//   After a good checksum, enter VERIFY with MemWrite=0.
//   Present Address=BASE_ADDR+i for i=0..N-1 on consecutive cycles.
//   Sum MemVal, one cycle behind the address. A final sum different from the checksum -> ERR, err_code 3.
//   Otherwise -> DONE N+2 cycles after the checksum edge.
//  LOADER_VERIFY_EN not defined: VERIFY does not exist; CSUM goes straight to DONE; err_code 3 never occurs.
// TESTING
//  1. reset=0 for 2 cycles with start=1 and in_valid=1 -> IDLE; all outputs 0; no MemWrite.
//  2. start; stream 3, 0x0008, 0x0814, 0x8014, 0x8830 ->
//     MemWrite pulses at Address 0, 1, 2 with that data; done=1; cpu_hold=0; words_loaded=3.
//  3. As 2 but checksum 0x0000 -> error=1, err_code=2, cpu_hold=1, done=0.
//     A following start -> HDR, error cleared.
//  4. Header 0, then separately header 258 -> error=1, err_code=1, no MemWrite pulse in either case.
//  5. Stream with in_valid gaps; reset=0 after 2 data words ->
//     next cycle MemWrite=0, in_ready=0, words_loaded=0, cpu_hold=0.
//  6. LOADER_VERIFY_EN, memory model corrupts addr 1 -> err_code=3.
//     Clean model -> done exactly N+2 cycles after the checksum edge.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams a program image (length N, N data words, checksum)
// into main memory through its Address/DataIn/MemWrite port and holds the
// CPU halted until the image is loaded and its checksum matches.
// Optional feature macro: LOADER_VERIFY_EN -- after a good checksum, read the
// image back through MemVal and compare its sum before releasing the CPU.
module program_loader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 257
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataIn,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemVal,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] words_loaded
);

  // Counter width covers N up to 2^ADDR_W plus the verify tail (N+1).
  localparam int CW = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0]     MAXW  = CW'(MAX_WORDS);

  // The image must fit below the top of the address space so Address never wraps.
  if ((longint'(BASE_ADDR) + longint'(MAX_WORDS)) > (longint'(1) << ADDR_W) ||
      MAX_WORDS < 1) begin : g_bad_cfg
    $error("program_loader: BASE_ADDR+MAX_WORDS exceeds 2^ADDR_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
`ifdef LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;         // image length from header
  logic [CW-1:0]     cnt_q, cnt_d;     // data words written so far
  logic [DATA_W-1:0] sum_q, sum_d;     // running checksum of data words
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [1:0]        ec_q, ec_d;
  logic              xfer;

`ifdef LOADER_VERIFY_EN
  // vcyc counts edges since the checksum edge; reads are issued for
  // vcyc 0..N-1 and MemVal lands two edges later (registered addr + memory).
  logic [CW-1:0]     vcyc_q, vcyc_d;
  logic [DATA_W-1:0] vsum_q, vsum_d;
`else
  logic unused_memval;
  assign unused_memval = ^MemVal;
`endif

  assign xfer = in_valid & in_ready;

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    ec_d     = ec_q;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
`ifdef LOADER_VERIFY_EN
    vcyc_d   = vcyc_q;
    vsum_d   = vsum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        in_ready = 1'b1;
        if (xfer) begin
          n_d = CW'(in_data);
          if (in_data == '0 || CW'(in_data) > MAXW) begin
            state_d = S_ERR;
            ec_d    = 2'd1;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (xfer) begin
          addr_d = BASE + cnt_q[ADDR_W-1:0];
          data_d = in_data;
          we_d   = 1'b1;
          sum_d  = sum_q + in_data;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == n_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (in_data == sum_q) begin
`ifdef LOADER_VERIFY_EN
            state_d = S_VERIFY;
            addr_d  = BASE;
            vcyc_d  = '0;
            vsum_d  = '0;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_ERR;
            ec_d    = 2'd2;
          end
        end
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        vcyc_d = vcyc_q + 1'b1;
        if (vcyc_q + 1'b1 < n_q) addr_d = BASE + ADDR_W'(vcyc_q + 1'b1);
        if (vcyc_q >= CW'(1) && vcyc_q <= n_q) vsum_d = vsum_q + MemVal;
        if (vcyc_q == n_q + 1'b1) begin
          if (vsum_q == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            ec_d    = 2'd3;
          end
        end
      end
`endif
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_ERR: begin
        error = 1'b1;
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          ec_d    = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ec_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ec_q    <= ec_d;
    end
  end

`ifdef LOADER_VERIFY_EN
  // Readback counter and sum registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vcyc_q <= '0;
      vsum_q <= '0;
    end else begin
      vcyc_q <= vcyc_d;
      vsum_q <= vsum_d;
    end
  end
`endif

  assign Address      = addr_q;
  assign DataIn       = data_q;
  assign MemWrite     = we_q;
  assign err_code     = ec_q;
  assign words_loaded = cnt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected memory writes,
// behavioural 16-bit memory with optional read corruption at address 1.
module tb_program_loader;
  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_ready, MemWrite;
  logic [15:0] in_data, Address, DataIn, MemVal, words_loaded;
  logic        cpu_hold, done, error;
  logic [1:0]  err_code;

  int          total = 0, bad = 0, wr_cnt = 0;
  logic [31:0] sb[$];
  bit          corrupt = 1'b0;
  logic [15:0] mem [0:65535];

  always #5 clock = ~clock;

  program_loader dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .Address(Address),
    .DataIn(DataIn), .MemWrite(MemWrite), .MemVal(MemVal),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  // Synchronous memory: write on MemWrite, registered read one cycle later.
  always @(posedge clock) begin
    if (MemWrite) mem[Address] <= DataIn;
    MemVal <= (corrupt && Address == 16'd1) ? (mem[Address] ^ 16'h0001) : mem[Address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected {address,data}.
  always @(negedge clock) begin
    if (MemWrite === 1'b1) begin
      wr_cnt++;
      chk("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("write_addr_data", {Address, DataIn}, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    int tmo = 0;
    in_valid = 1'b1; in_data = w;
    while (!in_ready && tmo < 50) begin tick(); tmo++; end
    chk("ready_seen", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_data(input int i, input logic [15:0] w);
    sb.push_back({16'(i), w});
    send(w);
  endtask

  task automatic wait_end();
    int tmo = 0;
    while (!(done | error) && tmo < 40) begin tick(); tmo++; end
  endtask

  initial begin
    logic [15:0] img [3];
    int w0;
    img[0] = 16'h0008; img[1] = 16'h0814; img[2] = 16'h8014;

    // 1: reset with start and in_valid active
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 16'hffff;
    tick(); tick();
    chk("rst_flags", {26'd0, in_ready, MemWrite, cpu_hold, done, error, 1'b0}, 32'd0);
    chk("rst_addr_data", {Address, DataIn}, 32'd0);
    chk("rst_ec_wl", {14'd0, err_code, words_loaded}, 32'd0);
    chk("rst_no_writes", wr_cnt, 0);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_ready", {in_ready, cpu_hold}, 2'b00);

    // 2: good image, with an ignored start in the middle of DATA
    pulse_start();
    chk("hdr_ready_hold", {in_ready, cpu_hold}, 2'b11);
    send(16'd3);
    send_data(0, img[0]);
    chk("wl_mid", words_loaded, 1);
    pulse_start();
    send_data(1, img[1]);
    send_data(2, img[2]);
    send(16'h8830);
    wait_end();
    chk("good_done_err", {done, error}, 2'b10);
    chk("good_hold_ready", {cpu_hold, in_ready}, 2'b00);
    chk("good_wl", words_loaded, 3);
    chk("good_sb_empty", sb.size(), 0);

    // 3: bad checksum, then restart clears error
    pulse_start();
    send(16'd3);
    for (int i = 0; i < 3; i++) send_data(i, img[i]);
    send(16'h0000);
    chk("csum_err", {done, error, cpu_hold}, 3'b011);
    chk("csum_code", err_code, 2);
    pulse_start();
    chk("restart_clear", {error, err_code, in_ready}, 4'b0001);

    // 4: bad headers 0 and 258 produce no writes
    w0 = wr_cnt;
    send(16'd0);
    chk("len0_err", {error, err_code}, 3'b101);
    tick(); tick();
    chk("len0_nowr", wr_cnt, w0);
    pulse_start();
    send(16'd258);
    chk("len258_err", {error, err_code}, 3'b101);
    tick(); tick();
    chk("len258_nowr", wr_cnt, w0);

    // 5: gaps in the stream, reset after two data words
    pulse_start();
    send(16'd4);
    tick(); tick();
    send_data(0, 16'h1111);
    tick(); tick(); tick();
    send_data(1, 16'h2222);
    chk("gap_wl", words_loaded, 2);
    reset = 1'b0;
    tick();
    chk("midrst", {MemWrite, in_ready, cpu_hold}, 3'b000);
    chk("midrst_wl", words_loaded, 0);
    reset = 1'b1;
    tick();
    chk("mem_kept", {mem[0], mem[1]}, 32'h11112222);

`ifdef LOADER_VERIFY_EN
    // 6: clean readback -> done exactly N+2 cycles after the checksum edge
    pulse_start();
    send(16'd3);
    for (int i = 0; i < 3; i++) send_data(i, img[i]);
    send(16'h8830);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("verify_done_c%0d", c), 32'(done), 32'(c == 5));
    end
    // corrupted readback of address 1
    corrupt = 1'b1;
    pulse_start();
    send(16'd3);
    for (int i = 0; i < 3; i++) send_data(i, img[i]);
    send(16'h8830);
    wait_end();
    chk("verify_err", {done, error, err_code}, 4'b0111);
    corrupt = 1'b0;
`endif

    tick();
    chk("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
